// File: rtl/approx_mul_ha_pipe.sv
// Approximate unsigned multiplier: paired partial-product rows are merged by
// runtime-configurable half-adder cells, then summed through a 3-stage pipeline.
module approx_mul_ha_pipe #(
  parameter  int WIDTH = 8,
  localparam int CELLS = (WIDTH / 2) * (WIDTH - 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         x,
  input  logic [WIDTH-1:0]         y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH-1:0]       product,
  input  logic                     cfg_we,
  input  logic [$clog2(CELLS)-1:0] cfg_addr,
  input  logic [1:0]               cfg_mode,
  output logic                     cfg_err
);

  localparam int PAIRS = WIDTH / 2;
  localparam int PW    = WIDTH + 2;
  localparam int OW    = 2 * WIDTH;

  logic [1:0]       mode_q [CELLS];
  logic             cfg_err_q;
  logic             cfg_ok;

  logic             s1_valid_q;
  logic [WIDTH-1:0] x1_q;
  logic [WIDTH-1:0] y1_q;

  logic [PW-1:0]    pair_d [PAIRS];
  logic [PW-1:0]    pair_q [PAIRS];
  logic             s2_valid_q;

  logic [OW-1:0]    product_d;
  logic [OW-1:0]    product_q;
  logic             s3_valid_q;

  logic             advance;

  // The whole pipeline moves as one shift register, so bubbles are preserved.
  assign advance   = !s3_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = s3_valid_q;
  assign product   = product_q;
  assign cfg_err   = cfg_err_q;

  assign cfg_ok = cfg_we && !s1_valid_q && !s2_valid_q && !s3_valid_q &&
                  !in_valid && (32'(cfg_addr) < CELLS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) mode_q[i] <= 2'b00;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && !cfg_ok;
      if (cfg_ok) mode_q[cfg_addr] <= cfg_mode;
    end
  end

  // Per-pair reduction: cell j merges pp[2r][j] with pp[2r+1][j-1].
  always_comb begin
    logic [PW-1:0] acc;
    logic          a, b, s, c;
    logic [1:0]    m;
    acc = '0;
    a   = 1'b0;
    b   = 1'b0;
    s   = 1'b0;
    c   = 1'b0;
    m   = 2'b00;
    for (int r = 0; r < PAIRS; r++) begin
      acc = PW'(x1_q[2*r] & y1_q[0]);
      acc = acc + (PW'(x1_q[2*r+1] & y1_q[WIDTH-1]) << WIDTH);
      for (int j = 1; j < WIDTH; j++) begin
        a = x1_q[2*r] & y1_q[j];
        b = x1_q[2*r+1] & y1_q[j-1];
        m = mode_q[r*(WIDTH-1) + j - 1];
        case (m)
          2'b00:   begin s = a ^ b; c = a & b; end
          2'b01:   begin s = a | b; c = 1'b0;  end
          2'b10:   begin s = 1'b0;  c = a;     end
          default: begin s = 1'b0;  c = 1'b0;  end
        endcase
        acc = acc + (PW'(s) << j) + (PW'(c) << (j + 1));
      end
      pair_d[r] = acc;
    end
  end

  always_comb begin
    product_d = '0;
    for (int r = 0; r < PAIRS; r++) begin
      product_d = product_d + (OW'(pair_q[r]) << (2 * r));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      x1_q       <= '0;
      y1_q       <= '0;
      s2_valid_q <= 1'b0;
      for (int r = 0; r < PAIRS; r++) pair_q[r] <= '0;
      s3_valid_q <= 1'b0;
      product_q  <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        x1_q <= x;
        y1_q <= y;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        for (int r = 0; r < PAIRS; r++) pair_q[r] <= pair_d[r];
      end
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) product_q <= product_d;
    end
  end

endmodule
